// File: rtl/pipyv_pkg.sv
// Shared definitions for the pipyv memory path: LSU size codes, IO window base
// and the memory-controller state encoding.
package pipyv_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } ls_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } mem_state_e;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  // Size code 3 is unused by the LSU; treat it as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  size_bytes = 3'd1;
      SIZE_H:  size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational byte-lane helper: selects the outgoing write byte, merges an
// incoming read byte into the little-endian accumulator, and zero-extends.
module mem_byte_lane
  import pipyv_pkg::*;
(
  input  logic [31:0] wdata_i,
  input  logic [1:0]  idx_i,
  input  logic [31:0] acc_i,
  input  logic [7:0]  din_i,
  input  logic [1:0]  size_i,
  output logic [7:0]  wbyte_o,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  always_comb begin
    wbyte_o  = 8'h00;
    merged_o = acc_i;
    case (idx_i)
      2'd0: begin
        wbyte_o        = wdata_i[7:0];
        merged_o[7:0]  = din_i;
      end
      2'd1: begin
        wbyte_o        = wdata_i[15:8];
        merged_o[15:8] = din_i;
      end
      2'd2: begin
        wbyte_o         = wdata_i[23:16];
        merged_o[23:16] = din_i;
      end
      default: begin
        wbyte_o         = wdata_i[31:24];
        merged_o[31:24] = din_i;
      end
    endcase

    case (size_i)
      SIZE_B:  rdata_o = {24'h0, merged_o[7:0]};
      SIZE_H:  rdata_o = {16'h0, merged_o[15:0]};
      default: rdata_o = merged_o;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and LSU traffic
// onto an 8-bit synchronous RAM. Optional feature: MEM_CTRL_IO_STALL_EN.
module mem_ctrl
  import pipyv_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  mem_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              hold_vld_q, hold_vld_d;
  logic              fresh_q, fresh_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       acc_q, acc_d;
  logic [7:0]        hold_q, hold_d;

  logic [2:0]  nbytes;
  logic [1:0]  lane_idx;
  logic [7:0]  byte_in;
  logic [7:0]  wbyte;
  logic [31:0] merged;
  logic [31:0] rdata;
  logic        io_stall;

  assign nbytes   = size_bytes(size_q);
  // Writes drive byte cnt; reads capture the byte addressed one cycle earlier.
  assign lane_idx = (state_q == LS_WR) ? cnt_q[1:0] : (cnt_q[1:0] - 2'd1);
  assign byte_in  = hold_vld_q ? hold_q : mem_din;

`ifdef MEM_CTRL_IO_STALL_EN
  localparam logic [ADDR_W-1:0] IO_MASK = ADDR_W'(IO_BASE);
  assign io_stall = (state_q == LS_WR) && ((base_q & IO_MASK) == IO_MASK) && io_buffer_full;
`else
  logic io_full_unused;
  assign io_full_unused = io_buffer_full;
  assign io_stall       = 1'b0;
`endif

  mem_byte_lane u_lane (
    .wdata_i  (wdata_q),
    .idx_i    (lane_idx),
    .acc_i    (acc_q),
    .din_i    (byte_in),
    .size_i   (size_q),
    .wbyte_o  (wbyte),
    .merged_o (merged),
    .rdata_o  (rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_vld_d = hold_vld_q;
    fresh_d    = 1'b0;
    base_d     = base_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    acc_d      = acc_q;
    hold_d     = hold_q;
    if_done    = 1'b0;
    if_data    = '0;
    ls_done    = 1'b0;
    ls_rdata   = '0;
    mem_wr     = 1'b0;
    mem_a      = '0;
    mem_dout   = '0;

    case (state_q)
      IDLE: begin
        hold_vld_d = 1'b0;
        if (rdy_in) begin
          if (ls_req) begin
            base_d  = ls_addr;
            size_d  = ls_size;
            wdata_d = ls_wdata;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ls_we ? LS_WR : LS_RD;
          end else if (if_req) begin
            base_d  = if_addr;
            size_d  = SIZE_W;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IF_RD;
          end
        end
      end

      IF_RD, LS_RD: begin
        mem_a = base_q + ADDR_W'(cnt_q);
        if (!rdy_in) begin
          // The RAM keeps running while frozen: keep the byte that was in flight.
          if (fresh_q && !hold_vld_q) begin
            hold_d     = mem_din;
            hold_vld_d = 1'b1;
          end
        end else if ((state_q == IF_RD) && if_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          hold_vld_d = 1'b0;
          if (cnt_q != 3'd0) acc_d = merged;
          if (cnt_q == nbytes) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == IF_RD) begin
              if_done = 1'b1;
              if_data = rdata;
            end else begin
              ls_done  = 1'b1;
              ls_rdata = rdata;
            end
          end else begin
            cnt_d   = cnt_q + 3'd1;
            fresh_d = 1'b1;
          end
        end
      end

      LS_WR: begin
        mem_a    = base_q + ADDR_W'(cnt_q);
        mem_dout = wbyte;
        if (rdy_in && !io_stall) begin
          mem_wr = 1'b1;
          if (cnt_q == (nbytes - 3'd1)) begin
            ls_done = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset also silences outputs within the cycle it is asserted.
    if (rst) begin
      if_done  = 1'b0;
      if_data  = '0;
      ls_done  = 1'b0;
      ls_rdata = '0;
      mem_wr   = 1'b0;
      mem_a    = '0;
      mem_dout = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hold_vld_q <= 1'b0;
      fresh_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_vld_q <= hold_vld_d;
      fresh_q    <= fresh_d;
    end
  end

  always_ff @(posedge clk) begin
    base_q  <= base_d;
    size_q  <= size_d;
    wdata_q <= wdata_d;
    acc_q   <= acc_d;
    hold_q  <= hold_d;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a registered byte-wide RAM model.
// Build with MEM_CTRL_IO_STALL_EN to exercise the IO write stall.
module tb_mem_ctrl;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, rdy_in;
  logic          if_req, if_flush, if_done;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_data;
  logic          ls_req, ls_we, ls_done;
  logic [1:0]    ls_size;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata, ls_rdata;
  logic [7:0]    mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr, io_buffer_full;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] ram [0:65535];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    mem_din <= ram[mem_a[15:0]];
  end

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy_in         (rdy_in),
    .if_req         (if_req),
    .if_addr        (if_addr),
    .if_flush       (if_flush),
    .if_done        (if_done),
    .if_data        (if_data),
    .ls_req         (ls_req),
    .ls_we          (ls_we),
    .ls_size        (ls_size),
    .ls_addr        (ls_addr),
    .ls_wdata       (ls_wdata),
    .ls_done        (ls_done),
    .ls_rdata       (ls_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({if_done, ls_done, mem_wr} !== 3'b000) begin
      n_bad++; $display("FAIL reset_strobes got=%b want=000", {if_done, ls_done, mem_wr});
    end
    n_vec++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h00) begin
      n_bad++; $display("FAIL reset_mem_bus got a=%h dout=%h want 0/0", mem_a, mem_dout);
    end
    n_vec++;
    if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_data got if=%h ls=%h want 0/0", if_data, ls_rdata);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin
      n_bad++; $display("FAIL idle_bus got a=%h wr=%b want 0/0", mem_a, mem_wr);
    end
  endtask

  task automatic test_if_read();
    int done_at = -1;
    int pulses = 0;
    logic [31:0] got = '0;
    ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h00;
    ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h93;
    if_addr = 32'h100; if_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) if_req = 1'b0;
      if (c <= 4) begin
        n_vec++;
        if (mem_a !== 32'h100 + 32'(c - 1)) begin
          n_bad++; $display("FAIL if_addr_seq c=%0d got=%h want=%h", c, mem_a, 32'h100 + 32'(c - 1));
        end
      end
      if (if_done) begin
        pulses++;
        if (done_at < 0) begin done_at = c; got = if_data; end
      end
    end
    n_vec++;
    if (done_at != 5) begin n_bad++; $display("FAIL if_done_cycle got=%0d want=5", done_at); end
    n_vec++;
    if (pulses != 1) begin n_bad++; $display("FAIL if_done_width got=%0d want=1", pulses); end
    n_vec++;
    if (got !== 32'h9300_0013) begin n_bad++; $display("FAIL if_data got=%h want=93000013", got); end
  endtask

  task automatic test_arbitration();
    int ls_at = -1;
    int if_at = -1;
    logic [31:0] got = '0;
    logic [31:0] wexp = 32'hDEAD_BEEF;
    logic [31:0] wram;
    ram[16'h0300] = 8'h01; ram[16'h0301] = 8'h02;
    ram[16'h0302] = 8'h03; ram[16'h0303] = 8'h04;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h200; ls_wdata = wexp;
    if_req = 1'b1; if_addr = 32'h300;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) begin
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0BAD_F00D;
      end
      if (c <= 4) begin
        n_vec++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h200 + 32'(c - 1) || mem_dout !== wexp[8*(c-1) +: 8]) begin
          n_bad++; $display("FAIL sw_byte c=%0d got wr=%b a=%h d=%h want 1/%h/%h", c, mem_wr, mem_a,
                            mem_dout, 32'h200 + 32'(c - 1), wexp[8*(c-1) +: 8]);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (mem_a !== 32'h300) begin n_bad++; $display("FAIL if_after_ls_addr got=%h want=300", mem_a); end
      end
      if (ls_done && ls_at < 0) ls_at = c;
      if (if_done && if_at < 0) begin if_at = c; got = if_data; if_req = 1'b0; end
    end
    wram = {ram[16'h0203], ram[16'h0202], ram[16'h0201], ram[16'h0200]};
    n_vec++;
    if (ls_at != 4) begin n_bad++; $display("FAIL arb_ls_done got=%0d want=4", ls_at); end
    n_vec++;
    if (if_at != 10) begin n_bad++; $display("FAIL arb_if_done got=%0d want=10", if_at); end
    n_vec++;
    if (got !== 32'h0403_0201) begin n_bad++; $display("FAIL arb_if_data got=%h want=04030201", got); end
    n_vec++;
    if (wram !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_ram got=%h want=deadbeef", wram); end
  endtask

  task automatic test_ls_read();
    logic [31:0] ad [3] = '{32'h0000_03FF, 32'h0000_03FE, 32'hFFFF_FFFE};
    logic [1:0]  sz [3] = '{2'd0, 2'd1, 2'd2};
    int          nb [3] = '{1, 2, 4};
    logic [31:0] ex [3] = '{32'h0000_0080, 32'h0000_8034, 32'hD4C3_B2A1};
    ram[16'h03FE] = 8'h34; ram[16'h03FF] = 8'h80;
    ram[16'hFFFE] = 8'hA1; ram[16'hFFFF] = 8'hB2;
    ram[16'h0000] = 8'hC3; ram[16'h0001] = 8'hD4;
    for (int v = 0; v < 3; v++) begin
      int done_at = -1;
      logic [31:0] got = '0;
      ls_req = 1'b1; ls_we = 1'b0; ls_size = sz[v]; ls_addr = ad[v];
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (c == 1) ls_req = 1'b0;
        if (c <= nb[v]) begin
          n_vec++;
          if (mem_a !== ad[v] + 32'(c - 1)) begin
            n_bad++; $display("FAIL ld_addr v=%0d c=%0d got=%h want=%h", v, c, mem_a, ad[v] + 32'(c - 1));
          end
        end
        if (ls_done && done_at < 0) begin done_at = c; got = ls_rdata; end
      end
      n_vec++;
      if (done_at != nb[v] + 1) begin
        n_bad++; $display("FAIL ld_done v=%0d got=%0d want=%0d", v, done_at, nb[v] + 1);
      end
      n_vec++;
      if (got !== ex[v]) begin n_bad++; $display("FAIL ld_data v=%0d got=%h want=%h", v, got, ex[v]); end
    end
  endtask

  task automatic test_rdy_stall();
    int done_at = -1;
    int pulses = 0;
    logic wr_seen = 1'b0;
    logic [31:0] got = '0;
    ram[16'h0140] = 8'h11; ram[16'h0141] = 8'h22;
    ram[16'h0142] = 8'h33; ram[16'h0143] = 8'h44;
    if_req = 1'b1; if_addr = 32'h140;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) if_req = 1'b0;
      if (c == 2) rdy_in = 1'b0;
      if (c == 5) rdy_in = 1'b1;
      if (c == 3) begin
        n_vec++;
        if (mem_a !== 32'h141) begin n_bad++; $display("FAIL stall_addr_hold got=%h want=141", mem_a); end
      end
      wr_seen = wr_seen | mem_wr;
      if (if_done) begin
        pulses++;
        if (done_at < 0) begin done_at = c; got = if_data; end
      end
    end
    n_vec++;
    if (done_at != 8) begin n_bad++; $display("FAIL stall_done got=%0d want=8", done_at); end
    n_vec++;
    if (pulses != 1) begin n_bad++; $display("FAIL stall_done_width got=%0d want=1", pulses); end
    n_vec++;
    if (got !== 32'h4433_2211) begin n_bad++; $display("FAIL stall_data got=%h want=44332211", got); end
    n_vec++;
    if (wr_seen !== 1'b0) begin n_bad++; $display("FAIL stall_mem_wr got=%b want=0", wr_seen); end
  endtask

  task automatic test_flush();
    int done_at = -1;
    logic if_seen = 1'b0;
    logic [31:0] got = '0;
    if_req = 1'b1; if_addr = 32'h100;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) begin
        if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h3FF;
      end
      if (c == 2) if_flush = 1'b1;
      if (c == 3) begin
        if_flush = 1'b0;
        n_vec++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin
          n_bad++; $display("FAIL flush_idle got a=%h wr=%b want 0/0", mem_a, mem_wr);
        end
      end
      if (c == 4) ls_req = 1'b0;
      if_seen = if_seen | if_done;
      if (ls_done && done_at < 0) begin done_at = c; got = ls_rdata; end
    end
    n_vec++;
    if (if_seen !== 1'b0) begin n_bad++; $display("FAIL flush_if_done got=%b want=0", if_seen); end
    n_vec++;
    if (done_at != 5 || got !== 32'h80) begin
      n_bad++; $display("FAIL flush_ls got cyc=%0d data=%h want 5/00000080", done_at, got);
    end
    done_at = -1;
    ls_req = 1'b1; ls_addr = 32'h3FF; if_flush = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) ls_req = 1'b0;
      if (ls_done && done_at < 0) done_at = c;
    end
    if_flush = 1'b0;
    n_vec++;
    if (done_at != 2) begin n_bad++; $display("FAIL flush_ignored_ls got=%0d want=2", done_at); end
  endtask

  task automatic test_back_to_back();
    int first_at = -1;
    int second_at = -1;
    logic [31:0] got = '0;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h500; ls_wdata = 32'h0000_005A;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        n_vec++;
        if (mem_wr !== 1'b1 || mem_dout !== 8'h5A || mem_a !== 32'h500) begin
          n_bad++; $display("FAIL sb_bus got wr=%b d=%h a=%h want 1/5a/500", mem_wr, mem_dout, mem_a);
        end
      end
      if (ls_done) begin
        if (first_at < 0) first_at = c;
        else if (second_at < 0) begin second_at = c; got = ls_rdata; end
      end
      if (c == 1) begin ls_we = 1'b0; ls_wdata = 32'h0; end
      if (c == 3) ls_req = 1'b0;
    end
    n_vec++;
    if (first_at != 1) begin n_bad++; $display("FAIL b2b_sb_done got=%0d want=1", first_at); end
    n_vec++;
    if (second_at != 4 || got !== 32'h5A) begin
      n_bad++; $display("FAIL b2b_lb got cyc=%0d data=%h want 4/0000005a", second_at, got);
    end
  endtask

  task automatic test_reset_mid();
    logic done_seen = 1'b0;
    int done_at = -1;
    logic [31:0] got = '0;
    for (int i = 0; i < 4; i++) ram[16'h0600 + 16'(i)] = 8'hAA;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h600; ls_wdata = 32'h1122_3344;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) ls_req = 1'b0;
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        rst = 1'b0;
        n_vec++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin
          n_bad++; $display("FAIL rst_mid_idle got a=%h wr=%b want 0/0", mem_a, mem_wr);
        end
      end
      done_seen = done_seen | ls_done;
    end
    n_vec++;
    if (done_seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done got=%b want=0", done_seen); end
    n_vec++;
    if (ram[16'h0600] !== 8'h44 || ram[16'h0602] !== 8'hAA || ram[16'h0603] !== 8'hAA) begin
      n_bad++; $display("FAIL rst_mid_ram got %h,%h,%h want 44,aa,aa", ram[16'h0600], ram[16'h0602], ram[16'h0603]);
    end
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h600;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) ls_req = 1'b0;
      if (ls_done && done_at < 0) begin done_at = c; got = ls_rdata; end
    end
    n_vec++;
    if (done_at != 2 || got !== 32'h44) begin
      n_bad++; $display("FAIL rst_recover got cyc=%0d data=%h want 2/00000044", done_at, got);
    end
  endtask

  task automatic test_io();
    int wr_at = -1;
    int done_at = -1;
    logic wr_while_full = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_addr = 32'h0003_0000; ls_wdata = 32'h41;
    io_buffer_full = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) ls_req = 1'b0;
`ifdef MEM_CTRL_IO_STALL_EN
      if (c == 4) io_buffer_full = 1'b0;
`else
      if (c == 6) io_buffer_full = 1'b0;
`endif
      if (mem_wr && io_buffer_full) wr_while_full = 1'b1;
      if (mem_wr && wr_at < 0) wr_at = c;
      if (ls_done && done_at < 0) done_at = c;
    end
`ifdef MEM_CTRL_IO_STALL_EN
    n_vec++;
    if (wr_while_full !== 1'b0) begin n_bad++; $display("FAIL io_wr_while_full got=1 want=0"); end
    n_vec++;
    if (wr_at != 4 || done_at != 4) begin
      n_bad++; $display("FAIL io_stall got wr=%0d done=%0d want 4/4", wr_at, done_at);
    end
`else
    n_vec++;
    if (wr_while_full !== 1'b1) begin n_bad++; $display("FAIL io_ignored got=0 want=1"); end
    n_vec++;
    if (wr_at != 1 || done_at != 1) begin
      n_bad++; $display("FAIL io_ignored_timing got wr=%0d done=%0d want 1/1", wr_at, done_at);
    end
`endif
    n_vec++;
    if (ram[16'h0000] !== 8'h41) begin n_bad++; $display("FAIL io_ram got=%h want=41", ram[16'h0000]); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    rst = 1'b1; rdy_in = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'd0; ls_addr = '0; ls_wdata = '0;
    io_buffer_full = 1'b0;
    test_reset();
    test_if_read();       tick();
    test_arbitration();   tick();
    test_ls_read();       tick();
    test_rdy_stall();     tick();
    test_flush();         tick();
    test_back_to_back();  tick();
    test_reset_mid();     tick();
    test_io();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
